// File: rtl/regfile_mp.sv
// Multi-port register file: two registered read ports, two write ports (port 2 wins),
// optional write-to-read forwarding, optional hardwired-zero register 0, post-reset clear sweep.
module regfile_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd1,
    input  logic [ADDR_WIDTH-1:0] rd2,
    input  logic [ADDR_WIDTH-1:0] wr1,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    input  logic                  wr1_enable,
    input  logic [ADDR_WIDTH-1:0] wr2,
    input  logic [DATA_WIDTH-1:0] wr2_data,
    input  logic                  wr2_enable,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic [DATA_WIDTH-1:0] rd2_data,
    output logic                  busy
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_RD    = 2;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                               state, state_nxt;
    logic [ADDR_WIDTH-1:0]                sweep_cnt;
    logic [DATA_WIDTH-1:0]                regs [DEPTH];
    logic                                 wr1_go, wr2_go;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_next, rd_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    // Next state: the sweep ends on the edge that clears the last register
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (&sweep_cnt) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == CLEAR);
    end

    // Sweep counter wraps to 0 naturally as the last register is cleared
    always_ff @(posedge clock) begin
        if (reset)              sweep_cnt <= '0;
        else if (state == CLEAR) sweep_cnt <= sweep_cnt + 1'b1;
    end

    // Address-0 writes vanish when register 0 is hardwired, which also keeps them off the bypass path
    always_comb begin
        wr1_go = wr1_enable && !busy && !((ZERO_REG != 0) && (wr1 == '0));
        wr2_go = wr2_enable && !busy && !((ZERO_REG != 0) && (wr2 == '0));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[sweep_cnt] <= '0;
            end else begin
                if (wr1_go) regs[wr1] <= wr1_data;
                if (wr2_go) regs[wr2] <= wr2_data;
            end
        end
    end

    assign rd_addr = {rd2, rd1};

    always_comb begin
        rd_next = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_next[p] = regs[rd_addr[p]];
            if (BYPASS != 0) begin
                if (wr2_go && (wr2 == rd_addr[p]))      rd_next[p] = wr2_data;
                else if (wr1_go && (wr1 == rd_addr[p])) rd_next[p] = wr1_data;
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) rd_next[p] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || busy) rd_q <= '0;
        else               rd_q <= rd_next;
    end

    assign rd1_data = rd_q[0];
    assign rd2_data = rd_q[1];

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 16, register and data-port width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, address width; depth = 2**ADDR_WIDTH registers.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = no forwarding.
REQ-004 Parameter ZERO_REG, default 0, 1 = register 0 hardwired to zero.
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rd1  input  ADDR_WIDTH  read port 1 address.
REQ-008 rd2  input  ADDR_WIDTH  read port 2 address.
REQ-009 wr1  input  ADDR_WIDTH  write port 1 address.
REQ-010 wr1_data  input  DATA_WIDTH  write port 1 data.
REQ-011 wr1_enable  input  1  write port 1 enable.
REQ-012 wr2  input  ADDR_WIDTH  write port 2 address.
REQ-013 wr2_data  input  DATA_WIDTH  write port 2 data.
REQ-014 wr2_enable  input  1  write port 2 enable.
REQ-015 rd1_data  output  DATA_WIDTH  registered read port 1 data.
REQ-016 rd2_data  output  DATA_WIDTH  registered read port 2 data.
REQ-017 busy  output  1  high while the post-reset clear sweep is running.

Function
REQ-018 The block SHALL implement a two-state FSM, CLEAR and IDLE, plus an ADDR_WIDTH-bit sweep counter.
REQ-019 In CLEAR with reset low, each edge SHALL write zero to register[counter] and increment the counter; after the edge that clears register depth-1, the state SHALL become IDLE (busy low from the following cycle).
REQ-020 busy SHALL be high in CLEAR and low in IDLE; busy SHALL stay high for exactly 2**ADDR_WIDTH cycles after reset deasserts.
REQ-021 While busy, wr1_enable/wr2_enable SHALL be ignored and rd1_data/rd2_data SHALL be loaded with zero.
REQ-022 In IDLE, an enabled write SHALL commit wrN_data to register[wrN] at the rising edge.
REQ-023 Both writes enabled to the same address SHALL commit wr2_data only (port 2 wins).
REQ-024 In IDLE, each edge SHALL load rdN_data with register[rdN] as sampled at that edge (read latency one cycle, both ports independent).
REQ-025 BYPASS=1: if rdN equals an enabled write address in the same cycle, rdN_data SHALL load that write's data, wr2 before wr1 by priority; BYPASS=0: rdN_data SHALL load the pre-write value.
REQ-026 ZERO_REG=1: writes to address 0 SHALL be discarded, reads of address 0 SHALL return zero, bypass SHALL NOT apply to address 0.
REQ-027 Address arithmetic SHALL be unsigned and modulo depth; the sweep counter SHALL wrap to 0 on entering IDLE.

Reset
REQ-028 reset high at a rising edge SHALL force state CLEAR, counter 0, busy 1, rd1_data 0, rd2_data 0, regardless of state or pending writes.
REQ-029 While reset is held, the counter SHALL stay at 0 and no register SHALL be written.
REQ-030 reset asserted mid-sweep SHALL restart the sweep from register 0 after release.

Verification (defaults: DATA_WIDTH 16, ADDR_WIDTH 3, BYPASS 1, ZERO_REG 0)
REQ-031 Reset 2 cycles then release -> busy high exactly 8 cycles then low; reading all 8 addresses returns 0x0000.
REQ-032 IDLE: wr1=1/0x0010 and wr2=2/0x0020 in one cycle; next cycle rd1=1, rd2=2 -> after following edge rd1_data=0x0010, rd2_data=0x0020.
REQ-033 wr1=5/0xAAAA and wr2=5/0x5555 same cycle -> subsequent read of 5 returns 0x5555.
REQ-034 wr1=3/0xABCD with rd1=3 same cycle -> rd1_data=0xABCD after that edge; rebuild BYPASS=0 -> 0x0000 then 0xABCD one cycle later.
REQ-035 wr1=4/0x1234 during busy -> after busy drops, read of 4 returns 0x0000; reset re-asserted at sweep cycle 4 -> busy high 8 full cycles after release.
REQ-036 ZERO_REG=1: wr1=0/0xFFFF with rd1=0 -> rd1_data=0x0000 that cycle and after.
